// File: rtl/dma_pkg.sv
// Shared types and default parameters for the device-to-memory DMA engine.
package dma_pkg;

  localparam int unsigned DMA_WORD_SIZE = 16;
  localparam int unsigned DMA_BURST_LEN = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FETCH,
    S_WRITE,
    S_RELEASE,
    S_DONE
  } dma_state_t;

endpackage

// File: rtl/dma_addr_gen.sv
// Destination address, remaining-word and per-tenure beat counters
// with the terminal-count flags used by the DMA FSM.
module dma_addr_gen
  import dma_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DMA_WORD_SIZE,
  parameter int unsigned BURST_LEN = DMA_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic [WORD_SIZE-1:0] load_addr_i,
  input  logic [WORD_SIZE-1:0] load_len_i,
  input  logic                 clr_beat_i,
  input  logic                 step_i,
  output logic [WORD_SIZE-1:0] cur_addr_o,
  output logic                 beat_last_o,
  output logic                 rem_last_o,
  output logic                 rem_zero_o
);

  localparam int unsigned BW = $clog2(BURST_LEN) + 1;
  localparam logic [BW-1:0] BEAT_TC = BW'(BURST_LEN - 1);

  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] rem_q, rem_d;
  logic [BW-1:0]        beat_q, beat_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q <= '0;
      rem_q  <= '0;
      beat_q <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      beat_q <= beat_d;
    end
  end

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    beat_d = beat_q;
    if (load_i) begin
      addr_d = load_addr_i;
      rem_d  = load_len_i;
      beat_d = '0;
    end else begin
      if (clr_beat_i) begin
        beat_d = '0;
      end
      // Address wraps naturally at the top of the word-address space.
      if (step_i) begin
        addr_d = addr_q + WORD_SIZE'(1);
        rem_d  = rem_q - WORD_SIZE'(1);
        beat_d = beat_q + BW'(1);
      end
    end
  end

  assign cur_addr_o  = addr_q;
  assign beat_last_o = (beat_q == BEAT_TC);
  assign rem_last_o  = (rem_q == WORD_SIZE'(1));
  assign rem_zero_o  = (rem_q == '0);

endmodule

// File: rtl/dma_controller.sv
// Bus-mastering DMA: moves device FIFO words into memory in bursts of
// BURST_LEN words, releasing the bus for one cycle between tenures.
module dma_controller
  import dma_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DMA_WORD_SIZE,
  parameter int unsigned BURST_LEN = DMA_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_len,
  output logic                 cmd_ready,
  output logic                 bus_req,
  input  logic                 bus_grant,
  input  logic                 dev_valid,
  input  logic [WORD_SIZE-1:0] dev_data,
  output logic                 dev_ready,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic                 dma_done
);

  dma_state_t           state_q, state_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 load, clr_beat, step;
  logic                 beat_last, rem_last, rem_zero;
  logic [WORD_SIZE-1:0] cur_addr;

  dma_addr_gen #(
    .WORD_SIZE (WORD_SIZE),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (load),
    .load_addr_i (cmd_addr),
    .load_len_i  (cmd_len),
    .clr_beat_i  (clr_beat),
    .step_i      (step),
    .cur_addr_o  (cur_addr),
    .beat_last_o (beat_last),
    .rem_last_o  (rem_last),
    .rem_zero_o  (rem_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
    end
  end

  // A dropped grant freezes FETCH/WRITE in place until the grant returns.
  always_comb begin
    state_d  = state_q;
    wdata_d  = wdata_q;
    load     = 1'b0;
    clr_beat = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          load    = 1'b1;
          state_d = (cmd_len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus_grant) begin
          clr_beat = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus_grant && dev_valid) begin
          wdata_d = dev_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus_grant && mem_ack) begin
          step    = 1'b1;
          state_d = (rem_last || beat_last) ? S_RELEASE : S_FETCH;
        end
      end
      S_RELEASE: state_d = rem_zero ? S_DONE : S_REQ;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign bus_req   = (state_q == S_REQ) || (state_q == S_FETCH) || (state_q == S_WRITE);
  assign busy      = (state_q != S_IDLE);
  assign dma_done  = (state_q == S_DONE);
  // The pop and the write strobe are gated by the live grant so neither can
  // reach the bus in the cycle an arbiter drops BG.
  assign dev_ready = (state_q == S_FETCH) && dev_valid && bus_grant;
  assign mem_write = (state_q == S_WRITE) && bus_grant;
  assign mem_addr  = cur_addr;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dma_controller.sv
// Randomized self-checking bench for dma_controller against a transfer-level model.
module tb_dma_controller;

  localparam int unsigned WS     = 16;
  localparam int unsigned BL     = 4;
  localparam int unsigned BUDGET = 1500;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic [WS-1:0] cmd_addr;
  logic [WS-1:0] cmd_len;
  logic          cmd_ready;
  logic          bus_req;
  logic          bus_grant;
  logic          dev_valid;
  logic [WS-1:0] dev_data;
  logic          dev_ready;
  logic          mem_write;
  logic [WS-1:0] mem_addr;
  logic [WS-1:0] mem_wdata;
  logic          mem_ack;
  logic          busy;
  logic          dma_done;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  dma_controller #(
    .WORD_SIZE (WS),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .dev_valid (dev_valid),
    .dev_data  (dev_data),
    .dev_ready (dev_ready),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .dma_done  (dma_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check_eq({tag, "_bus_req"},   32'(bus_req),   32'd0);
    check_eq({tag, "_dev_ready"}, 32'(dev_ready), 32'd0);
    check_eq({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check_eq({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_dma_done"},  32'(dma_done),  32'd0);
  endtask

  task automatic quiet_inputs();
    cmd_valid = 1'b0;
    bus_grant = 1'b0;
    dev_valid = 1'b0;
    mem_ack   = 1'b0;
  endtask

  // Entered and left at posedge+1. The expected write stream is simply
  // (addr+i mod 2^16, words[i]) for i < len, in ceil(len/BL) bus tenures.
  task automatic run_cmd(input logic [WS-1:0] addr, input int unsigned len,
                         input bit stall, input int unsigned abort_after);
    logic [WS-1:0] words[$];
    int unsigned nw, pops, falls, c, bursts, gcnt, wwait, last_fall, gdelay, adelay;
    bit prev_req, pend, finished, aborted;

    words.delete();
    for (int unsigned i = 0; i < len; i++) words.push_back(WS'($urandom));
    bursts = (len + BL - 1) / BL;
    gdelay = stall ? 5 : 0;
    adelay = stall ? 3 : 0;
    nw = 0; pops = 0; falls = 0; c = 0; gcnt = 0; wwait = 0; last_fall = 0;
    prev_req = 1'b0; pend = 1'b0; finished = 1'b0; aborted = 1'b0;

    quiet_inputs();
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = WS'(len);
    @(negedge clk);
    check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;

    while (!finished && !aborted && c < BUDGET) begin
      cmd_addr = WS'($urandom);
      cmd_len  = WS'($urandom);
      if (!bus_req) begin
        bus_grant = 1'b0;
        gcnt      = 0;
      end else begin
        bus_grant = (gcnt >= gdelay);
        if (stall && bus_grant && $urandom_range(0, 7) == 0) bus_grant = 1'b0;
        gcnt++;
      end
      dev_valid = (pops < len) && (!stall || $urandom_range(0, 1) == 1);
      dev_data  = (pops < len) ? words[pops] : WS'($urandom);
      mem_ack   = (wwait >= adelay);
      cmd_valid = stall && ($urandom_range(0, 1) == 1);

      @(negedge clk);
      if (c == 0) begin
        check_eq("req_after_accept", 32'(bus_req), 32'(len > 0));
        check_eq("done_len0", 32'(dma_done), 32'(len == 0));
      end
      check_eq("busy_in_xfer", 32'(busy), 32'd1);
      check_eq("cmd_ignored", 32'(cmd_ready), 32'd0);
      if (mem_write) check_eq("wr_needs_grant", 32'(bus_grant), 32'd1);
      if (dev_ready) check_eq("pop_needs_grant_valid", 32'(bus_grant & dev_valid), 32'd1);
      if (pend && bus_grant) check_eq("wr_held", 32'(mem_write), 32'd1);
      if (mem_write) begin
        if (nw < len) begin
          check_eq("wr_addr", 32'(mem_addr), 32'(WS'(addr + WS'(nw))));
          check_eq("wr_data", 32'(mem_wdata), 32'(words[nw]));
        end else begin
          check_eq("extra_write", nw, len);
        end
        if (mem_ack) begin
          nw++;
          wwait = 0;
          pend  = 1'b0;
        end else begin
          wwait++;
          pend = 1'b1;
        end
      end
      if (dev_ready) pops++;
      if (prev_req && !bus_req) begin
        falls++;
        last_fall = c;
      end
      if (!prev_req && bus_req && falls > 0)
        check_eq("release_one_cycle", c - last_fall, 32'd1);
      if (dma_done) begin
        finished = 1'b1;
        check_eq("done_words", nw, len);
        check_eq("done_pops", pops, len);
        if (len > 0) check_eq("done_after_release", c - last_fall, 32'd1);
        if (!stall) check_eq("latency", c, 2 * bursts + 2 * len);
      end
      prev_req = bus_req;
      if (abort_after != 0 && nw == abort_after) aborted = 1'b1;
      c++;
      @(posedge clk); #1;
    end

    quiet_inputs();
    if (aborted) begin
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("abort");
      @(posedge clk); #1;
    end else begin
      check_eq("done_timeout", 32'(finished), 32'd1);
      @(negedge clk);
      check_eq("done_single_pulse", 32'(dma_done), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("tenures", falls, bursts);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    dev_data = '0;
    quiet_inputs();
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_no_req", 32'(bus_req), 32'd0);
      @(posedge clk); #1;
    end

    run_cmd(16'h0100, 4, 1'b0, 0);
    run_cmd(16'h2000, 10, 1'b0, 0);
    run_cmd(16'h3000, 10, 1'b1, 0);
    run_cmd(16'h4000, 0, 1'b0, 0);
    run_cmd(16'hFFFE, 3, 1'b0, 0);
    run_cmd(16'hFFFE, 3, 1'b1, 0);
    run_cmd(16'h0500, 4, 1'b0, 2);
    run_cmd(16'h0600, 1, 1'b0, 0);
    for (int unsigned k = 0; k < 8; k++)
      run_cmd(WS'($urandom), $urandom_range(0, 13), 1'($urandom_range(0, 1)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
